// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
// Definitions shared by the UART transmitter and its serializer.
//   state_t    : transmitter FSM states (IDLE, START, DATA, STOP)
//   START_BIT  : line level driven during the start bit
//   STOP_BIT   : line level driven during the stop bit
//   IDLE_LEVEL : line level held while no frame is in progress
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_flex_pts_sr.sv
// flex_pts_sr
// Parallel-to-serial shift register with selectable bit order.
// serial_out always shows the bit at the head of the register. Each shift
// moves the next bit to the head and fills the vacated end with 1.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset, register becomes all ones
//   load_enable  : capture parallel_in (wins over shift_enable)
//   shift_enable : advance to the next bit
//   parallel_in  : word to serialize, NUM_BITS wide
//   serial_out   : current head bit (LSB when SHIFT_MSB=0, MSB when 1)
module flex_pts_sr #(
  parameter int   NUM_BITS  = 8,
  parameter logic SHIFT_MSB = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_enable,
  input  logic                shift_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);

  logic [NUM_BITS-1:0] r_shift;

  // Load beats shift so a new word is never corrupted by a stray shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '1;
    end else if (load_enable) begin
      r_shift <= parallel_in;
    end else if (shift_enable) begin
      if (SHIFT_MSB) begin
        r_shift <= {r_shift[NUM_BITS-2:0], 1'b1};
      end else begin
        r_shift <= {1'b1, r_shift[NUM_BITS-1:1]};
      end
    end
  end

  assign serial_out = SHIFT_MSB ? r_shift[NUM_BITS-1] : r_shift[0];

endmodule

// File: rtl/uart_tx.sv
// uart_tx
// UART transmitter: accepts a parallel word with a valid/ready handshake and
// sends it as start bit, NUM_BITS data bits, stop bit, each held for
// CLKS_PER_BIT cycles.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   tx_data    : word to send, NUM_BITS wide
//   tx_valid   : tx_data holds a word to send
//   tx_ready   : high only while idle; a word is taken when valid && ready
//   tx_busy    : inverse of tx_ready
//   serial_out : registered serial line, idles high
//   frame_done : one-cycle pulse in the last cycle of the stop bit
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int   NUM_BITS     = 8,
  parameter int   CLKS_PER_BIT = 10,
  parameter logic SHIFT_MSB    = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tx_busy,
  output logic                serial_out,
  output logic                frame_done
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int CW = $clog2(NUM_BITS + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(NUM_BITS - 1);

  state_t        r_state;
  state_t        w_nextState;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_nextTimer;
  logic [CW-1:0] r_bitCnt;
  logic [CW-1:0] w_nextBitCnt;
  logic          r_serial;
  logic          w_nextSerial;
  logic          w_load;
  logic          w_shift;
  logic          w_frameDone;
  logic          w_srBit;
  logic          w_bitEnd;

  flex_pts_sr #(
    .NUM_BITS  (NUM_BITS),
    .SHIFT_MSB (SHIFT_MSB)
  ) u_sr (
    .clk          (clk),
    .rst          (rst),
    .load_enable  (w_load),
    .shift_enable (w_shift),
    .parallel_in  (tx_data),
    .serial_out   (w_srBit)
  );

  // Timer counts 0..CLKS_PER_BIT-1 within each bit; with CLKS_PER_BIT=1 it
  // sits at 0 and every cycle is a bit boundary.
  assign w_bitEnd = (r_timer == TIMER_LAST);

  // State, timer, bit counter and line register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_bitCnt <= '0;
      r_serial <= IDLE_LEVEL;
    end else begin
      r_state  <= w_nextState;
      r_timer  <= w_nextTimer;
      r_bitCnt <= w_nextBitCnt;
      r_serial <= w_nextSerial;
    end
  end

  // Next-state logic. The line register is loaded one cycle ahead of each
  // bit period, so at every boundary into a data bit we copy the
  // serializer's head bit onto the line and shift in the same edge, which
  // puts the following bit at the head ready for the next boundary. The
  // last data boundary goes to the stop bit without shifting.
  always_comb begin
    w_nextState  = r_state;
    w_nextTimer  = r_timer + TW'(1);
    w_nextBitCnt = r_bitCnt;
    w_nextSerial = r_serial;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_frameDone  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_nextTimer  = '0;
        w_nextSerial = IDLE_LEVEL;
        if (tx_valid) begin
          w_load       = 1'b1;
          w_nextState  = START;
          w_nextSerial = START_BIT;
        end
      end
      START: begin
        if (w_bitEnd) begin
          w_nextTimer  = '0;
          w_nextState  = DATA;
          w_nextBitCnt = '0;
          w_nextSerial = w_srBit;
          w_shift      = 1'b1;
        end
      end
      DATA: begin
        if (w_bitEnd) begin
          w_nextTimer = '0;
          if (r_bitCnt == BIT_LAST) begin
            w_nextState  = STOP;
            w_nextSerial = STOP_BIT;
          end else begin
            w_nextBitCnt = r_bitCnt + CW'(1);
            w_nextSerial = w_srBit;
            w_shift      = 1'b1;
          end
        end
      end
      STOP: begin
        if (w_bitEnd) begin
          w_nextTimer  = '0;
          w_frameDone  = 1'b1;
          w_nextState  = IDLE;
          w_nextSerial = IDLE_LEVEL;
        end
      end
      default: begin
        w_nextState  = IDLE;
        w_nextSerial = IDLE_LEVEL;
      end
    endcase
  end

  assign tx_ready   = (r_state == IDLE);
  assign tx_busy    = ~tx_ready;
  assign serial_out = r_serial;
  assign frame_done = w_frameDone;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
// Drives three transmitters side by side: channel 0 LSB-first at 4 clocks
// per bit, channel 1 MSB-first at 4 clocks per bit, channel 2 LSB-first at
// 1 clock per bit. A frame-position model predicts every output each cycle;
// hand-written bit patterns pin the model for the key scenarios.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] txData [3];
  logic [2:0] txValid;
  logic [2:0] txReady;
  logic [2:0] txBusy;
  logic [2:0] serialOut;
  logic [2:0] frameDone;

  int vectors     = 0;
  int miscompares = 0;
  logic checking  = 1'b0;

  // Model state per channel: whether a frame is on the line, which cycle of
  // the frame the current cycle is (1-based), and the captured word.
  logic       active  [3] = '{1'b0, 1'b0, 1'b0};
  int         elapsed [3] = '{0, 0, 0};
  logic [7:0] word    [3];

  always #5 clk = ~clk;

  uart_tx #(.NUM_BITS(8), .CLKS_PER_BIT(4), .SHIFT_MSB(1'b0)) dutLsb (
    .clk(clk), .rst(rst), .tx_data(txData[0]), .tx_valid(txValid[0]),
    .tx_ready(txReady[0]), .tx_busy(txBusy[0]), .serial_out(serialOut[0]),
    .frame_done(frameDone[0]));

  uart_tx #(.NUM_BITS(8), .CLKS_PER_BIT(4), .SHIFT_MSB(1'b1)) dutMsb (
    .clk(clk), .rst(rst), .tx_data(txData[1]), .tx_valid(txValid[1]),
    .tx_ready(txReady[1]), .tx_busy(txBusy[1]), .serial_out(serialOut[1]),
    .frame_done(frameDone[1]));

  uart_tx #(.NUM_BITS(8), .CLKS_PER_BIT(1), .SHIFT_MSB(1'b0)) dutFast (
    .clk(clk), .rst(rst), .tx_data(txData[2]), .tx_valid(txValid[2]),
    .tx_ready(txReady[2]), .tx_busy(txBusy[2]), .serial_out(serialOut[2]),
    .frame_done(frameDone[2]));

  function automatic int cpbOf(input int c);
    return (c == 2) ? 1 : 4;
  endfunction

  function automatic int frameLen(input int c);
    return 10 * cpbOf(c);
  endfunction

  // Line level for the current cycle: bit slot 0 is the start bit, slots
  // 1..8 carry data in the channel's order, slot 9 is the stop bit.
  function automatic logic expSerial(input int c);
    int slot;
    int pos;
    if (!active[c]) return 1'b1;
    slot = (elapsed[c] - 1) / cpbOf(c);
    if (slot == 0) return 1'b0;
    if (slot <= 8) begin
      pos = slot - 1;
      return (c == 1) ? word[c][7-pos] : word[c][pos];
    end
    return 1'b1;
  endfunction

  function automatic logic expDone(input int c);
    return active[c] && (elapsed[c] == frameLen(c));
  endfunction

  function automatic logic [39:0] expand(input logic [9:0] pat, input int cpb);
    logic [39:0] v;
    v = '0;
    for (int k = 0; k < 10 * cpb; k++) v[k] = pat[k / cpb];
    return v;
  endfunction

  task automatic checkOutput(input string name, input int c,
                             input logic [39:0] actual, input logic [39:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s ch%0d: got %0h expected %0h", name, c, actual, expected);
    end
  endtask

  // Model advance: reset wins, a running frame ends after its last cycle
  // (leaving one idle cycle), and an idle channel takes a valid word.
  always @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (rst) begin
        active[c] = 1'b0;
      end else if (active[c]) begin
        if (elapsed[c] == frameLen(c)) active[c] = 1'b0;
        else elapsed[c]++;
      end else if (txValid[c]) begin
        active[c]  = 1'b1;
        elapsed[c] = 1;
        word[c]    = txData[c];
      end
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (checking) begin
      for (int c = 0; c < 3; c++) begin
        checkOutput("serial_out", c, 40'(serialOut[c]), 40'(expSerial(c)));
        checkOutput("tx_ready",   c, 40'(txReady[c]),   40'(!active[c]));
        checkOutput("tx_busy",    c, 40'(txBusy[c]),    40'(active[c]));
        checkOutput("frame_done", c, 40'(frameDone[c]), 40'(expDone(c)));
      end
    end
  end

  // Offer one word on channel c, capture len cycles of the line and the
  // done pulse, count cycles with ready low, and check ready returns.
  task automatic applyStimulus(input int c, input logic [7:0] d, input int len,
                               output logic [39:0] ser, output logic [39:0] done,
                               output int readyLow);
    ser      = '0;
    done     = '0;
    readyLow = 0;
    @(negedge clk);
    #1 txValid[c] = 1'b1;
    txData[c] = d;
    @(posedge clk);
    #1 txValid[c] = 1'b0;
    txData[c] = ~d;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      ser[k]  = serialOut[c];
      done[k] = frameDone[c];
      if (!txReady[c]) readyLow++;
    end
    @(negedge clk);
    checkOutput("ready_after_frame", c, 40'(txReady[c]), 40'd1);
  endtask

  initial begin
    logic [39:0] ser;
    logic [39:0] done;
    int          readyLow;
    logic        gapSerial, gapReady, f2Start, f2Ready, f1Bit0, f2Bit0;
    int          doneSeen;

    rst     = 1'b1;
    txValid = '0;
    for (int c = 0; c < 3; c++) txData[c] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checking = 1'b1;
    checkOutput("reset_serial", 0, 40'(serialOut), 40'(3'b111));
    checkOutput("reset_ready",  0, 40'(txReady),   40'(3'b111));
    checkOutput("reset_busy",   0, 40'(txBusy),    40'(3'b000));
    checkOutput("reset_done",   0, 40'(frameDone), 40'(3'b000));
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0x35 LSB first: 0 | 1,0,1,0,1,1,0,0 | 1
    applyStimulus(0, 8'h35, 40, ser, done, readyLow);
    checkOutput("lsb_0x35_line", 0, ser, expand(10'b1001101010, 4));
    checkOutput("lsb_0x35_done", 0, done, 40'h80_0000_0000);
    checkOutput("lsb_0x35_busy_cycles", 0, 40'(readyLow), 40'd40);

    // 0x01 MSB first: 0 | 0,0,0,0,0,0,0,1 | 1
    applyStimulus(1, 8'h01, 40, ser, done, readyLow);
    checkOutput("msb_0x01_line", 1, ser, expand(10'b1100000000, 4));
    checkOutput("msb_0x01_done", 1, done, 40'h80_0000_0000);
    checkOutput("msb_0x01_busy_cycles", 1, 40'(readyLow), 40'd40);

    // 0xFF at one clock per bit: 0 then nine ones, done in cycle 10
    applyStimulus(2, 8'hFF, 10, ser, done, readyLow);
    checkOutput("fast_0xFF_line", 2, ser, 40'h00_0000_03FE);
    checkOutput("fast_0xFF_done", 2, done, 40'h00_0000_0200);
    checkOutput("fast_0xFF_busy_cycles", 2, 40'(readyLow), 40'd10);

    // Back-to-back with valid held: 0x55, then 0xAA presented mid-frame.
    repeat (2) @(negedge clk);
    #1 txValid[0] = 1'b1;
    txData[0] = 8'h55;
    for (int k = 1; k <= 82; k++) begin
      @(negedge clk);
      if (k == 5)  f1Bit0 = serialOut[0];
      if (k == 41) begin gapSerial = serialOut[0]; gapReady = txReady[0]; end
      if (k == 42) begin f2Start = serialOut[0]; f2Ready = txReady[0]; end
      if (k == 46) f2Bit0 = serialOut[0];
      if (k == 20) #1 txData[0] = 8'hAA;
      if (k == 60) begin #1 txData[0] = 8'h0F; txValid[0] = 1'b0; end
    end
    checkOutput("b2b_first_bit0",  0, 40'(f1Bit0),    40'd1);
    checkOutput("b2b_gap_serial",  0, 40'(gapSerial), 40'd1);
    checkOutput("b2b_gap_ready",   0, 40'(gapReady),  40'd1);
    checkOutput("b2b_second_start",0, 40'(f2Start),   40'd0);
    checkOutput("b2b_second_busy", 0, 40'(f2Ready),   40'd0);
    checkOutput("b2b_second_bit0", 0, 40'(f2Bit0),    40'd0);

    // Reset pulsed in cycle 17 of a frame abandons it without a done pulse.
    repeat (2) @(negedge clk);
    #1 txValid[0] = 1'b1;
    txData[0] = 8'h35;
    doneSeen = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (frameDone[0]) doneSeen++;
      if (k == 1) #1 txValid[0] = 1'b0;
    end
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    if (frameDone[0]) doneSeen++;
    checkOutput("abort_serial", 0, 40'(serialOut[0]), 40'd1);
    checkOutput("abort_ready",  0, 40'(txReady[0]),   40'd1);
    checkOutput("abort_no_done",0, 40'(doneSeen),     40'd0);
    applyStimulus(0, 8'hC3, 40, ser, done, readyLow);
    checkOutput("after_abort_line", 0, ser, expand(10'b1110000110, 4));
    checkOutput("after_abort_done", 0, done, 40'h80_0000_0000);

    // Reset and valid on the same edge: nothing starts.
    @(negedge clk);
    #1 rst = 1'b1;
    txValid[0] = 1'b1;
    txData[0] = 8'h5A;
    @(posedge clk);
    #1 rst = 1'b0;
    txValid[0] = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid_serial", 0, 40'(serialOut[0]), 40'd1);
    checkOutput("rst_valid_ready",  0, 40'(txReady[0]),   40'd1);
    repeat (4) @(negedge clk);
    checkOutput("rst_valid_still_idle", 0, 40'(serialOut[0]), 40'd1);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
